// File: rtl/hid_event_encoder.sv
// hid_event_encoder: converts keyboard, mouse and gamepad reports into 4-byte
// records {tag, d0, d1, d2} queued in a byte FIFO with a valid/ready output.
// Optional feature: define HID_KEYUP_EN to emit key-up records from the KUP scan.
module hid_event_encoder #(
  parameter int unsigned NKEYS      = 6,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned X_MAX      = 1023,
  parameter int unsigned Y_MAX      = 767
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [1:0]         usb_type,
  input  logic               usb_report,
  input  logic [7:0]         key_modifiers,
  input  logic [8*NKEYS-1:0] keys,
  input  logic [2:0]         mouse_btn,
  input  logic [7:0]         mouse_dx,
  input  logic [7:0]         mouse_dy,
  input  logic [9:0]         game_btns,
  output logic               busy,
  output logic               report_lost,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         drop_cnt
);

  localparam int unsigned SW = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, KDOWN, KUP, PUSH} state_t;

  state_t             state, state_nxt, ret_state;
  logic [7:0]         cur_k  [NKEYS];
  logic [7:0]         prev_k [NKEYS];
  logic [7:0]         mods;
  logic [SW-1:0]      slot;
  logic [9:0]         pos_x, pos_y, game;
  logic [31:0]        rec;
  logic [1:0]         bidx;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;

  logic               last, room, want, dn_hit, fifo_wr, drop, rd;
  logic signed [11:0] sum_x, sum_y;
  logic [9:0]         nx, ny;
`ifdef HID_KEYUP_EN
  logic               up_hit;
`endif

  assign last      = (slot == SW'(NKEYS - 1));
  assign room      = (count <= CW'(FIFO_DEPTH - 4));
  assign busy      = (state != IDLE);
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;
  assign rd        = out_valid && out_ready;

  // Key-set membership of the slot currently being scanned
  always_comb begin
    dn_hit = (cur_k[slot] != 8'h00);
`ifdef HID_KEYUP_EN
    up_hit = (prev_k[slot] != 8'h00);
`endif
    for (int i = 0; i < int'(NKEYS); i++) begin
      if (prev_k[i] == cur_k[slot]) dn_hit = 1'b0;
`ifdef HID_KEYUP_EN
      if (cur_k[i] == prev_k[slot]) up_hit = 1'b0;
`endif
    end
  end

  // Clamped mouse position after applying the signed deltas
  always_comb begin
    sum_x = $signed({2'b00, pos_x}) + $signed({{4{mouse_dx[7]}}, mouse_dx});
    sum_y = $signed({2'b00, pos_y}) + $signed({{4{mouse_dy[7]}}, mouse_dy});
    if (sum_x < 0)                          nx = 10'd0;
    else if (sum_x > $signed(12'(X_MAX)))   nx = 10'(X_MAX);
    else                                    nx = sum_x[9:0];
    if (sum_y < 0)                          ny = 10'd0;
    else if (sum_y > $signed(12'(Y_MAX)))   ny = 10'(Y_MAX);
    else                                    ny = sum_y[9:0];
  end

  // A record is wanted this cycle (pushed if room, otherwise dropped)
  always_comb begin
    want = 1'b0;
    case (state)
      IDLE:  if (usb_report) begin
               if (usb_type == 2'd2)      want = 1'b1;
               else if (usb_type == 2'd3) want = (game_btns != game);
             end
      KDOWN: want = dn_hit;
`ifdef HID_KEYUP_EN
      KUP:   want = up_hit;
`endif
      default: want = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (usb_report) begin
               if (usb_type == 2'd1)   state_nxt = KDOWN;
               else if (want && room)  state_nxt = PUSH;
             end
      KDOWN: if (want && room)         state_nxt = PUSH;
             else if (last)            state_nxt = KUP;
`ifdef HID_KEYUP_EN
      KUP:   if (want && room)         state_nxt = PUSH;
             else if (last)            state_nxt = IDLE;
`else
      KUP:                             state_nxt = IDLE;
`endif
      PUSH:  if (bidx == 2'd3)         state_nxt = ret_state;
      default:                         state_nxt = IDLE;
    endcase
  end

  // FSM outputs: FIFO write strobe and drop strobe
  always_comb begin
    fifo_wr = 1'b0;
    drop    = 1'b0;
    if (state == PUSH) fifo_wr = 1'b1;
    if (want && !room) drop = 1'b1;
  end

  // Report latching, scan bookkeeping and record assembly
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < int'(NKEYS); i++) begin
        cur_k[i]  <= 8'h00;
        prev_k[i] <= 8'h00;
      end
      mods        <= 8'h00;
      slot        <= '0;
      pos_x       <= 10'd0;
      pos_y       <= 10'd0;
      game        <= 10'd0;
      rec         <= 32'h0;
      bidx        <= 2'd0;
      ret_state   <= IDLE;
      report_lost <= 1'b0;
      drop_cnt    <= 8'h00;
    end else begin
      report_lost <= usb_report && (usb_type != 2'd0) && (state != IDLE);
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
      case (state)
        IDLE: if (usb_report) begin
          ret_state <= IDLE;
          case (usb_type)
            2'd1: begin
              for (int i = 0; i < int'(NKEYS); i++) cur_k[i] <= keys[8*i +: 8];
              mods <= key_modifiers;
              slot <= '0;
            end
            2'd2: begin
              pos_x <= nx;
              pos_y <= ny;
              rec   <= {8'h4D, nx[7:0], ny[7:0], 1'b0, mouse_btn, ny[9:8], nx[9:8]};
            end
            2'd3: begin
              game <= game_btns;
              rec  <= {8'h47, game_btns[7:0], 6'b0, game_btns[9:8], 8'h00};
            end
            default: ;
          endcase
        end
        KDOWN: begin
          rec       <= {8'h4B, cur_k[slot], mods, 8'h00};
          ret_state <= last ? KUP : KDOWN;
          slot      <= last ? '0 : slot + SW'(1);
        end
        KUP: begin
`ifdef HID_KEYUP_EN
          rec       <= {8'h6B, prev_k[slot], mods, 8'h00};
          ret_state <= last ? IDLE : KUP;
          slot      <= last ? '0 : slot + SW'(1);
          if (last) for (int i = 0; i < int'(NKEYS); i++) prev_k[i] <= cur_k[i];
`else
          for (int i = 0; i < int'(NKEYS); i++) prev_k[i] <= cur_k[i];
`endif
        end
        PUSH: begin
          rec  <= {rec[23:0], 8'h00};
          bidx <= bidx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd)      rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(fifo_wr) - CW'(rd);
    end
  end

  // FIFO storage; contents are don't-care until covered by occupancy
  always_ff @(posedge clk) begin
    if (resetn && fifo_wr) mem[wr_ptr] <= rec[31:24];
  end

endmodule
